// File: rtl/lzss_flag_packer.sv
// LZSS token packer: groups up to 8 tokens behind a flag byte,
// buffering literal/match payload bytes until the group is emitted.
module lzss_flag_packer #(
  parameter logic MATCH_FLAG = 1'b1
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        FIFO_EMPTY,
  input  logic [16:0] FIFO_DATA,
  output logic        FIFO_READ,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  output logic [7:0]  OUT_DATA,
  input  logic        OUT_READY,
  output logic        DONE
);

  typedef enum logic [1:0] {
    COLLECT,
    EMIT_FLAG,
    EMIT_DATA
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  tcnt;
  logic [4:0]  wcnt;
  logic [3:0]  rcnt;
  logic [7:0]  flag;
  logic        flush_pend;
  logic [7:0]  mem [16];
  logic        last;
  logic        is_match;
  logic [3:0]  widx;

  assign is_match = FIFO_DATA[16];
  assign widx     = wcnt[3:0];
  assign last     = ({1'b0, rcnt} == (wcnt - 5'd1));

  always_comb begin
    state_nx  = state;
    FIFO_READ = 1'b0;
    OUT_VALID = 1'b0;
    OUT_DATA  = 8'h00;
    DONE      = 1'b0;
    unique case (state)
      COLLECT: begin
        // gated by RSTB so no pop is requested while held in reset
        FIFO_READ = RSTB & ~FIFO_EMPTY & (tcnt < 4'd8);
        if (FIFO_READ) begin
          if (tcnt == 4'd7)
            state_nx = EMIT_FLAG;
        end else if (flush_pend & FIFO_EMPTY) begin
          if (tcnt == 4'd0)
            DONE = 1'b1;
          else
            state_nx = EMIT_FLAG;
        end
      end
      EMIT_FLAG: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = flag;
        if (OUT_READY)
          state_nx = EMIT_DATA;
      end
      EMIT_DATA: begin
        OUT_VALID = 1'b1;
        OUT_DATA  = mem[rcnt];
        if (OUT_READY && last)
          state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state      <= COLLECT;
      tcnt       <= 4'd0;
      wcnt       <= 5'd0;
      rcnt       <= 4'd0;
      flag       <= 8'h00;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (DONE)
        flush_pend <= 1'b0;
      else if (FLUSH)
        flush_pend <= 1'b1;
      if (FIFO_READ) begin
        flag[tcnt[2:0]] <= is_match ? MATCH_FLAG : ~MATCH_FLAG;
        tcnt <= tcnt + 4'd1;
        wcnt <= wcnt + (is_match ? 5'd2 : 5'd1);
      end
      if (state == EMIT_FLAG && OUT_READY)
        rcnt <= 4'd0;
      if (state == EMIT_DATA && OUT_READY) begin
        if (last) begin
          tcnt <= 4'd0;
          wcnt <= 5'd0;
          rcnt <= 4'd0;
          flag <= 8'h00;
        end else begin
          rcnt <= rcnt + 4'd1;
        end
      end
    end
  end

  // payload buffer is never reset; entries are written before read
  always_ff @(posedge CLK) begin
    if (FIFO_READ) begin
      if (is_match) begin
        mem[widx]        <= FIFO_DATA[15:8];
        mem[widx + 4'd1] <= FIFO_DATA[7:0];
      end else begin
        mem[widx] <= FIFO_DATA[7:0];
      end
    end
  end

endmodule
